// File: rtl/pulse_seq_pkg.sv
// Shared encodings for the pulse sequencer host command scheduler.
// Latency: none (types, constants and one pure helper function).
// Backpressure: not applicable.
package pulse_seq_pkg;

   // Header byte opcode field, bits [7:6]
   typedef enum logic [1:0] {
      OP_WRITE    = 2'b00,
      OP_START    = 2'b01,
      OP_STOP     = 2'b10,
      OP_HALT_ALL = 2'b11
   } op_e;

   // Frame parser states; B3..B0 name the value byte expected next
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_B3     = 3'd1,
      ST_B2     = 3'd2,
      ST_B1     = 3'd3,
      ST_B0     = 3'd4,
      ST_COMMIT = 3'd5
   } state_e;

   // Header byte layout
   typedef struct packed {
      op_e        op;
      logic [1:0] ch;
      logic [3:0] mask;
   } hdr_t;

   localparam int NUM_CH          = 4;
   localparam int SET_BITS_PER_CH = 4;

   // Bit index of each load strobe inside a channel's 4-bit setting group
   localparam int SET_INITIAL_STATE = 0;
   localparam int SET_INITIAL_COUNT = 1;
   localparam int SET_HI_COUNT      = 2;
   localparam int SET_LO_COUNT      = 3;

   localparam int SETTING_W = NUM_CH * SET_BITS_PER_CH;

   // Place a channel's strobe mask into its slot of the full setting word
   function automatic logic [SETTING_W-1:0] setting_word(input logic [1:0] ch,
                                                         input logic [3:0] mask);
      logic [SETTING_W-1:0] w;
      w = '0;
      w[SET_BITS_PER_CH*int'(ch) +: SET_BITS_PER_CH] = mask;
      return w;
   endfunction

endpackage

// File: rtl/pulse_seq_timeout.sv
// Inter-byte gap counter: counts idle cycles while a frame is open.
// Latency: expired is a combinational view of the registered count.
// Backpressure: none; saturates at TIMEOUT_CYCLES until cleared.
module pulse_seq_timeout #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 11
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins, otherwise step while running, holding at the limit
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (run && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = run && (cnt_q == LIMIT);

endmodule

// File: rtl/pulse_seq_scheduler.sv
// Host byte-stream parser driving four pulse sequencer channels (load strobes, run enables).
// Latency: START/STOP/HALT act on the header edge; WRITE strobes one cycle after the last value byte.
// Backpressure: cmd_ready low only in the single COMMIT cycle and during reset.
module pulse_seq_scheduler
   import pulse_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 11
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           cmd,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   output logic [31:0]          value,
   output logic [SETTING_W-1:0] setting,
   output logic [NUM_CH-1:0]    operate,
   output logic                 err
);

   state_e              state_q, state_d;
   logic [31:0]         value_q, value_d;
   logic [NUM_CH-1:0]   operate_q, operate_d;
   logic [3:0]          mask_q, mask_d;
   logic [1:0]          ch_q, ch_d;
   logic                blk_q, blk_d;
   logic                err_q, err_d;
   logic                live_q, live_d;

   hdr_t                hdr;
   logic                cmd_acc;
   logic                in_data;
   logic                tmo_expired;

   assign hdr       = hdr_t'(cmd);
   assign cmd_ready = live_q && (state_q != ST_COMMIT);
   assign cmd_acc   = cmd_valid && cmd_ready;
   assign in_data   = (state_q == ST_B3) || (state_q == ST_B2) ||
                      (state_q == ST_B1) || (state_q == ST_B0);

   // Idle-gap watchdog; held cleared whenever no frame is open
   pulse_seq_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (cmd_acc || !in_data),
      .run     (in_data),
      .expired (tmo_expired)
   );

   // Frame parser: decode headers, collect value bytes, abort on gap timeout
   always_comb begin
      state_d   = state_q;
      value_d   = value_q;
      operate_d = operate_q;
      mask_d    = mask_q;
      ch_d      = ch_q;
      blk_d     = blk_q;
      err_d     = 1'b0;
      live_d    = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (cmd_acc) begin
               case (hdr.op)
                  OP_WRITE: begin
                     state_d = ST_B3;
                     mask_d  = hdr.mask;
                     ch_d    = hdr.ch;
                     // A running channel must not be reloaded; remember that now
                     blk_d   = operate_q[hdr.ch];
                  end
                  OP_START:    operate_d = operate_q | hdr.mask;
                  OP_STOP:     operate_d = operate_q & ~hdr.mask;
                  OP_HALT_ALL: operate_d = '0;
                  default:     operate_d = operate_q;
               endcase
            end
         end
         ST_B3: begin
            if (cmd_acc) begin
               value_d[31:24] = cmd;
               state_d        = ST_B2;
            end
         end
         ST_B2: begin
            if (cmd_acc) begin
               value_d[23:16] = cmd;
               state_d        = ST_B1;
            end
         end
         ST_B1: begin
            if (cmd_acc) begin
               value_d[15:8] = cmd;
               state_d       = ST_B0;
            end
         end
         ST_B0: begin
            if (cmd_acc) begin
               value_d[7:0] = cmd;
               state_d      = ST_COMMIT;
               // Rejected write flags err during COMMIT; an empty mask is a silent no-op
               err_d        = blk_q && (mask_q != 4'b0000);
            end
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A byte arriving in the expiry cycle wins over the abort
      if (in_data && !cmd_acc && tmo_expired) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
      end
   end

   // Load strobes exist only in COMMIT and only for an accepted write
   always_comb begin
      setting = '0;
      if ((state_q == ST_COMMIT) && !blk_q) begin
         setting = setting_word(ch_q, mask_q);
      end
   end

   // State registers; reset discards any open frame silently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         value_q   <= '0;
         operate_q <= '0;
         mask_q    <= '0;
         ch_q      <= '0;
         blk_q     <= 1'b0;
         err_q     <= 1'b0;
         live_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         value_q   <= value_d;
         operate_q <= operate_d;
         mask_q    <= mask_d;
         ch_q      <= ch_d;
         blk_q     <= blk_d;
         err_q     <= err_d;
         live_q    <= live_d;
      end
   end

   assign value   = value_q;
   assign operate = operate_q;
   assign err     = err_q;

endmodule

// File: tb/tb_pulse_seq_scheduler.sv
// Self-checking bench for pulse_seq_scheduler: frame-level model plus directed literal checks.
// Latency: inputs driven on the falling edge, outputs compared on the falling edge.
// Backpressure: the byte sender waits (bounded) for cmd_ready before presenting a byte.
module tb_pulse_seq_scheduler;

   localparam int TO = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  cmd = 8'h00;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] value;
   logic [15:0] setting;
   logic [3:0]  operate;
   logic        err;

   int n_pass = 0;
   int n_tot  = 0;
   bit chk_en = 1'b0;

   pulse_seq_scheduler #(.TIMEOUT_CYCLES(TO), .CNT_W(11)) dut (
      .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .value(value), .setting(setting), .operate(operate), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- frame-level reference model ----------------
   int          m_left   = 0;     // value bytes still owed by the open WRITE frame
   bit          m_commit = 1'b0;  // the cycle right after the last value byte
   int          m_gap    = 0;     // consecutive idle cycles inside the open frame
   logic [31:0] m_val    = '0;
   logic [3:0]  m_op     = '0;
   logic [3:0]  m_mask   = '0;
   logic [1:0]  m_ch     = '0;
   bit          m_blk    = 1'b0;
   bit          m_live   = 1'b0;
   bit          m_err    = 1'b0;
   bit          m_acc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0; m_commit = 0; m_gap = 0; m_val = '0; m_op = '0;
         m_mask = '0; m_ch = '0; m_blk = 0; m_live = 0; m_err = 0;
      end else begin
         m_acc = m_live && !m_commit && cmd_valid;
         m_err = 0;
         if (m_commit) begin
            m_commit = 0;
         end else if (m_left == 0) begin
            if (m_acc) begin
               case (cmd[7:6])
                  2'b00: begin
                     m_left = 4; m_gap = 0; m_mask = cmd[3:0]; m_ch = cmd[5:4];
                     m_blk = m_op[cmd[5:4]];
                  end
                  2'b01:   m_op = m_op | cmd[3:0];
                  2'b10:   m_op = m_op & ~cmd[3:0];
                  default: m_op = 4'b0000;
               endcase
            end
         end else if (m_acc) begin
            m_val[8*(m_left-1) +: 8] = cmd;
            m_left--;
            m_gap = 0;
            if (m_left == 0) begin
               m_commit = 1;
               m_err = m_blk && (m_mask != 4'b0000);
            end
         end else if (m_gap == TO) begin
            m_left = 0; m_gap = 0; m_err = 1;
         end else begin
            m_gap++;
         end
         m_live = 1;
      end
   end

   function automatic logic [15:0] exp_setting();
      logic [15:0] w;
      w = '0;
      if (m_commit && !m_blk) w[4*int'(m_ch) +: 4] = m_mask;
      return w;
   endfunction

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, m_live && !m_commit});
         chk("value", value, m_val);
         chk("setting", {16'b0, setting}, {16'b0, exp_setting()});
         chk("operate", {28'b0, operate}, {28'b0, m_op});
         chk("err", {31'b0, err}, {31'b0, m_err});
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [7:0] b);
      int w = 0;
      while (!cmd_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!cmd_ready) chk("ready_wait", {31'b0, cmd_ready}, 32'd1);
      cmd = b;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic send_write(input logic [7:0] hdr, input logic [31:0] v);
      send(hdr);
      send(v[31:24]);
      send(v[23:16]);
      send(v[15:8]);
      send(v[7:0]);
   endtask

   initial begin
      int   at;
      bit   seen;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_value", value, 32'h0);
      chk("rst_setting", {16'b0, setting}, 32'h0);
      chk("rst_operate", {28'b0, operate}, 32'h0);
      chk("rst_err", {31'b0, err}, 32'h0);
      chk("rst_ready", {31'b0, cmd_ready}, 32'h0);
      #2 rst_n = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", {31'b0, cmd_ready}, 32'd1);

      // WRITE ch2 mask 0110, back-to-back value bytes
      send_write(8'h26, 32'h12345678);
      chk("w_value", value, 32'h12345678);
      chk("w_setting", {16'b0, setting}, 32'h0600);
      chk("w_ready_commit", {31'b0, cmd_ready}, 32'd0);
      @(negedge clk);
      chk("w_setting_after", {16'b0, setting}, 32'h0);

      // START / STOP / HALT_ALL
      send(8'h4B);
      chk("start_1011", {28'b0, operate}, 32'hB);
      send(8'h81);
      chk("stop_0001", {28'b0, operate}, 32'hA);
      send(8'hC5);
      chk("halt_all", {28'b0, operate}, 32'h0);

      // Write to a running channel is consumed but rejected
      send(8'h71);
      chk("start_ch_ignored", {28'b0, operate}, 32'h1);
      send_write(8'h0F, 32'hCAFEF00D);
      chk("blk_err", {31'b0, err}, 32'd1);
      chk("blk_setting", {16'b0, setting}, 32'h0);
      chk("blk_operate", {28'b0, operate}, 32'h1);
      @(negedge clk);
      chk("blk_err_once", {31'b0, err}, 32'd0);

      // Empty mask: five bytes consumed, silent
      send_write(8'h20, 32'h0BADBEEF);
      chk("mask0_setting", {16'b0, setting}, 32'h0);
      chk("mask0_err", {31'b0, err}, 32'd0);
      chk("mask0_value", value, 32'h0BADBEEF);

      // Gap timeout abort after header plus two bytes
      send(8'h13);
      send(8'hAA);
      send(8'hBB);
      at = 0;
      seen = 0;
      for (int i = 1; i <= 1100 && at == 0; i++) begin
         @(negedge clk);
         if (setting != 16'h0) seen = 1;
         if (err) at = i;
      end
      chk("abort_cycle", at, 32'd1025);
      chk("abort_no_strobe", {31'b0, seen}, 32'd0);
      @(negedge clk);
      chk("abort_err_once", {31'b0, err}, 32'd0);
      send_write(8'h13, 32'h11223344);
      chk("post_abort_setting", {16'b0, setting}, 32'h0030);
      chk("post_abort_value", value, 32'h11223344);

      // Byte arriving exactly when the gap counter hits the limit is accepted
      send(8'h14);
      send(8'h01);
      repeat (TO) @(negedge clk);
      send(8'h02);
      send(8'h03);
      send(8'h04);
      chk("edge_err", {31'b0, err}, 32'd0);
      chk("edge_setting", {16'b0, setting}, 32'h0040);
      chk("edge_value", value, 32'h01020304);

      // Reset in the middle of a frame (state B1)
      send(8'h3F);
      send(8'hDE);
      send(8'hAD);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_value", value, 32'h0);
      chk("midrst_setting", {16'b0, setting}, 32'h0);
      chk("midrst_operate", {28'b0, operate}, 32'h0);
      chk("midrst_err", {31'b0, err}, 32'h0);
      chk("midrst_ready", {31'b0, cmd_ready}, 32'h0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_ready_after", {31'b0, cmd_ready}, 32'd1);
      repeat (6) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d of %0d checks passed", n_pass, n_tot);
      $fatal(1);
   end

endmodule

// File: doc/pulse_seq_scheduler.md
PULSE_SEQ_SCHEDULER -- requirements
Module: pulse_seq_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: maximum idle cycles allowed between bytes of one frame.
REQ-002 Parameter CNT_W, default 11: inter-byte gap counter width; SHALL satisfy 2^CNT_W > TIMEOUT_CYCLES.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd  input  8  host command byte.
REQ-006 cmd_valid  input  1  cmd holds a byte.
REQ-007 cmd_ready  output  1  block accepts cmd this cycle.
REQ-008 value  output  32  shared setting-value bus to all four sequencer channels.
REQ-009 setting  output  16  per-channel load strobes; bits [4c+3:4c] for channel c, order {lo_count, hi_count, initial_count, initial_state}.
REQ-010 operate  output  4  per-channel run enable.
REQ-011 err  output  1  one-cycle pulse on rejected or aborted frame.

Function
REQ-012 A byte SHALL be accepted exactly when cmd_valid && cmd_ready at a rising clk edge.
REQ-013 Header byte: [7:6] op, [5:4] channel, [3:0] mask; ops: 00 WRITE, 01 START, 10 STOP, 11 HALT_ALL.
REQ-014 States: IDLE, B3, B2, B1, B0, COMMIT; cmd_ready SHALL be 1 in IDLE and B3..B0, 0 in COMMIT.
REQ-015 WRITE header SHALL move IDLE->B3; the next four accepted bytes load value[31:24], [23:16], [15:8], [7:0] in that order, moving B3->B2->B1->B0->COMMIT.
REQ-016 In COMMIT, setting[4c+3:4c] SHALL equal the header mask for the addressed channel c, all other setting bits 0, with value stable; next state IDLE.
REQ-017 Strobe latency: exactly one cycle after the edge accepting the last value byte; strobes SHALL be 0 in every other state.
REQ-018 WRITE to a channel whose operate bit is 1 when the header is accepted: the value bytes SHALL still be consumed, but COMMIT issues no strobe and err pulses for one cycle in COMMIT.
REQ-019 WRITE with mask 0000 SHALL consume five bytes, issue no strobe, and not assert err.
REQ-020 START: operate[i] <= 1 for every i with mask[i]=1, all in the same cycle, on the edge accepting the header; channel field ignored; state stays IDLE.
REQ-021 STOP: operate[i] <= 0 for every i with mask[i]=1, same timing as START.
REQ-022 HALT_ALL: operate <= 4'b0000 regardless of mask.
REQ-023 Gap counter SHALL clear on every accepted byte and increment each cycle in B3..B0 without an accepted byte.
REQ-024 When the counter reaches TIMEOUT_CYCLES with no byte accepted that cycle, the frame SHALL be aborted: state <= IDLE, no strobe, err pulses one cycle.
REQ-025 A byte accepted in the cycle the counter reaches TIMEOUT_CYCLES SHALL win; no abort occurs.
REQ-026 value SHALL hold its last loaded contents outside WRITE frames; an aborted frame may leave value partially updated.

Reset
REQ-027 While rst_n=0: state IDLE, value 0, setting 0, operate 0, err 0, gap counter 0, cmd_ready 0.
REQ-028 cmd_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-029 Reset asserted mid-frame SHALL discard the frame with no strobe and no err.

Structure
REQ-030 Opcode encodings, state encodings and the setting-bit index constants SHALL live in shared package pulse_seq_pkg, reused by host software headers.
REQ-031 The gap counter SHALL be sub-module pulse_seq_timeout (inputs clear, run; output expired); all other logic is flat.

Verification
REQ-032 WRITE ch2 mask 0110, bytes 0x12,0x34,0x56,0x78 back-to-back -> one cycle later value=0x12345678, setting=0x0600, cmd_ready=0 that cycle.
REQ-033 START mask 1011 -> operate=1011 next cycle; then STOP mask 0001 -> operate=1010; then HALT_ALL -> 0000.
REQ-034 START mask 0001, then WRITE ch0 mask 1111 -> no setting strobe, err pulses once in COMMIT, operate unchanged.
REQ-035 WRITE header plus two bytes, then idle 1024 cycles -> err pulse, state IDLE, setting never nonzero; a new frame then completes normally.
REQ-036 Byte presented in the same cycle the gap counter reaches TIMEOUT_CYCLES -> byte accepted, no err, frame completes.
REQ-037 Assert rst_n=0 in B1 -> all outputs 0 immediately; cmd_ready=1 one cycle after release; no strobe observed.
